// File: rtl/r_fifo_rd_arb_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM state encoding and
// the burst-length defaults that write-side arbiters are expected to reuse.
package r_fifo_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int ARB_BURST_LEN  = 16;
    localparam int ARB_BURST_BITS = 5;

endpackage

// File: rtl/r_fifo_rd_arb_rr_select.sv
// Round-robin winner search: first set request bit scanning upward,
// circularly, starting one past the previous owner.
module rr_select #(
    parameter int N      = 4,
    parameter int N_BITS = 2
) (
    input  logic [N-1:0]      req,
    input  logic [N_BITS-1:0] last,
    output logic [N_BITS-1:0] win,
    output logic [N-1:0]      win_onehot,
    output logic              any
);

    int                j;
    logic [N_BITS-1:0] idx;

    // Scan last+1 .. last+N (mod N) and latch the first requester found.
    always_comb begin
        win        = '0;
        win_onehot = '0;
        any        = 1'b0;
        j          = 0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = N_BITS'(j);
            if (!any && req[idx]) begin
                any             = 1'b1;
                win             = idx;
                win_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/r_fifo_rd_arb.sv
// Round-robin arbiter sharing one FIFO read port among N consumers in
// bounded bursts. Issues FIFO_RE, never reads while the FIFO is empty, and
// tags each returned word with a one-hot strobe for its owner.
module r_fifo_rd_arb
    import r_fifo_rd_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int N          = 4,
    parameter int N_BITS     = 2,
    parameter int BURST_LEN  = ARB_BURST_LEN,
    parameter int BURST_BITS = ARB_BURST_BITS
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [N-1:0]     REQ,
    output logic [N-1:0]     GNT,
    output logic             FIFO_RE,
    input  logic             FIFO_EMPTY,
    input  logic [WIDTH-1:0] FIFO_Q,
    output logic [WIDTH-1:0] DOUT,
    output logic [N-1:0]     DOUT_VALID,
    output logic             BUSY
);

    localparam logic [BURST_BITS-1:0] BURST_MAX  = BURST_BITS'(BURST_LEN);
    localparam logic [N_BITS-1:0]     LAST_RESET = N_BITS'(N - 1);

    arb_state_t              state, state_nxt;
    logic [N-1:0]            gnt, gnt_nxt;
    logic [N_BITS-1:0]       gidx, gidx_nxt;
    logic [N_BITS-1:0]       last, last_nxt;
    logic [BURST_BITS-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [N-1:0]            dv, dv_nxt;
    logic                    re;

    logic [N_BITS-1:0]       win;
    logic [N-1:0]            win_onehot;
    logic                    win_any;

    rr_select #(
        .N      (N),
        .N_BITS (N_BITS)
    ) u_rr_select (
        .req        (REQ),
        .last       (last),
        .win        (win),
        .win_onehot (win_onehot),
        .any        (win_any)
    );

    // Next-state, read-enable and strobe scheduling for the arbiter FSM.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        gidx_nxt  = gidx;
        last_nxt  = last;
        cnt_nxt   = cnt;
        dv_nxt    = '0;
        re        = 1'b0;
        cnt_inc   = cnt + BURST_BITS'(1);
        case (state)
            ST_IDLE: begin
                if (win_any && !FIFO_EMPTY) begin
                    gnt_nxt   = win_onehot;
                    gidx_nxt  = win;
                    cnt_nxt   = '0;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                // Read only while the owner still asks, data exists and the
                // burst budget is not exhausted; cnt therefore saturates.
                re = REQ[gidx] && !FIFO_EMPTY && (cnt < BURST_MAX);
                if (re) begin
                    cnt_nxt = cnt_inc;
                    dv_nxt  = gnt;
                    if (cnt_inc == BURST_MAX) begin
                        state_nxt = ST_DRAIN;
                    end
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Grant still held this cycle so the final strobe lands
                // while the owner is visible; pointer moves on release.
                last_nxt  = gidx;
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset gives requester 0 first priority.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
            gnt   <= '0;
            gidx  <= '0;
            last  <= LAST_RESET;
            cnt   <= '0;
            dv    <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            gidx  <= gidx_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            dv    <= dv_nxt;
        end
    end

    assign FIFO_RE    = re;
    assign GNT        = gnt;
    assign DOUT_VALID = dv;
    assign DOUT       = FIFO_Q;
    assign BUSY       = (state != ST_IDLE);

endmodule

// File: tb/tb_r_fifo_rd_arb.sv
// Bench for r_fifo_rd_arb: FIFO model, transaction-level reference model,
// arbitration table, test-plan sequences and a randomized soak.
module tb_r_fifo_rd_arb;

    localparam int N  = 4;
    localparam int BL = 16;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] REQ   = '0;
    logic       FIFO_EMPTY;
    logic [7:0] FIFO_Q = '0;
    wire  [3:0] GNT;
    wire  [3:0] DOUT_VALID;
    wire        FIFO_RE;
    wire        BUSY;
    wire  [7:0] DOUT;

    r_fifo_rd_arb #(
        .WIDTH      (8),
        .N          (4),
        .N_BITS     (2),
        .BURST_LEN  (16),
        .BURST_BITS (5)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .REQ        (REQ),
        .GNT        (GNT),
        .FIFO_RE    (FIFO_RE),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_Q     (FIFO_Q),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .BUSY       (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // FIFO model: words in mem[rp..wp-1]; a read advances the tail at the edge.
    logic [7:0] mem [0:16383];
    int wp = 0;
    int rp = 0;
    logic flush = 1'b0;
    assign FIFO_EMPTY = (rp == wp);

    always @(posedge CLOCK) begin
        if (flush) begin
            rp <= wp;
        end else if (FIFO_RE && rp != wp) begin
            FIFO_Q <= mem[rp];
            rp     <= rp + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model state (phase 0 idle, 1 reading, 2 release cycle).
    int m_phase, m_g, m_reads, m_last, m_pend, m_rp;
    logic [7:0] m_word;
    // Observed statistics used by the directed sequences.
    int re_cnt = 0;
    int strobe_cnt [N];
    int rd_by [N];
    int grant_q [$];
    int burst_q [$];
    int cur_reads = 0;
    logic [3:0] prev_gnt = '0;

    task run_monitor;
        logic [3:0] eg, edv;
        logic er;
        int gi;
        forever begin
            @(negedge CLOCK);
            if (!RESET) begin
                m_phase = 0; m_g = -1; m_pend = -1; m_last = N - 1; m_rp = rp; m_reads = 0;
            end else begin
                eg  = (m_phase == 0) ? 4'b0 : (4'b1 << m_g);
                er  = (m_phase == 1) && REQ[m_g] && !FIFO_EMPTY && (m_reads < BL);
                edv = (m_pend >= 0) ? (4'b1 << m_pend) : 4'b0;
                chk("gnt", GNT, eg);
                chk("fifo_re", FIFO_RE, er);
                chk("dout_valid", DOUT_VALID, edv);
                chk("busy", BUSY, m_phase != 0);
                if (m_pend >= 0) chk("dout_data", DOUT, m_word);
                if (FIFO_RE) chk("re_while_empty", FIFO_EMPTY, 1'b0);
                m_pend = -1;
                case (m_phase)
                    0: if (REQ != 0 && !FIFO_EMPTY) begin
                        m_g = rr_pick(REQ, m_last); m_reads = 0; m_phase = 1;
                    end
                    1: if (er) begin
                        m_pend = m_g; m_word = mem[m_rp]; m_rp++; m_reads++;
                        if (m_reads == BL) m_phase = 2;
                    end else begin
                        m_phase = 2;
                    end
                    default: begin m_last = m_g; m_phase = 0; end
                endcase
            end
            if (prev_gnt == 0 && GNT != 0) begin
                grant_q.push_back(onehot_idx(GNT));
                cur_reads = 0;
            end
            if (FIFO_RE) begin
                re_cnt++;
                cur_reads++;
                gi = onehot_idx(GNT);
                if (gi >= 0) rd_by[gi]++;
            end
            for (int i = 0; i < N; i++) if (DOUT_VALID[i]) strobe_cnt[i]++;
            if (prev_gnt != 0 && GNT == 0) burst_q.push_back(cur_reads);
            prev_gnt = GNT;
        end
    endtask

    task push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = 8'($urandom);
            wp++;
        end
    endtask

    task step(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task do_reset;
        @(negedge CLOCK);
        #2;
        RESET = 1'b0;
        REQ   = '0;
        flush = 1'b1;
        @(posedge CLOCK);
        #1;
        flush = 1'b0;
        step(1);
        RESET = 1'b1;
    endtask

    task rst_checks(input string tag);
        chk({tag, "_gnt"}, GNT, 0);
        chk({tag, "_re"}, FIFO_RE, 0);
        chk({tag, "_dv"}, DOUT_VALID, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    typedef struct {
        logic [3:0] req;
        int         fill;
        logic [3:0] exp_gnt;
        logic       exp_re;
    } vec_t;

    vec_t tbl [7];

    int b0, b1, gb, bb, done;

    initial begin
        for (int i = 0; i < N; i++) begin strobe_cnt[i] = 0; rd_by[i] = 0; end
        fork
            run_monitor();
        join_none

        // Reset state
        #1;
        rst_checks("reset");
        do_reset();

        // Arbitration table: one request pattern from reset, grant one cycle later.
        tbl[0] = '{4'b0001, 2, 4'b0001, 1'b1};
        tbl[1] = '{4'b0110, 2, 4'b0010, 1'b1};
        tbl[2] = '{4'b1000, 2, 4'b1000, 1'b1};
        tbl[3] = '{4'b1111, 2, 4'b0001, 1'b1};
        tbl[4] = '{4'b1100, 2, 4'b0100, 1'b1};
        tbl[5] = '{4'b0000, 2, 4'b0000, 1'b0};
        tbl[6] = '{4'b1111, 0, 4'b0000, 1'b0};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            push(tbl[v].fill);
            REQ = tbl[v].req;
            @(negedge CLOCK);
            @(negedge CLOCK);
            chk("tbl_gnt", GNT, tbl[v].exp_gnt);
            chk("tbl_re", FIFO_RE, tbl[v].exp_re);
            step(1);
            REQ = '0;
            step(6);
        end

        // Single requester, 40 words: bursts of 16, 16, 8
        do_reset();
        push(40);
        b0 = strobe_cnt[0]; bb = burst_q.size();
        REQ = 4'b0001;
        for (int c = 0; c < 300 && burst_q.size() < bb + 3; c++) step(1);
        step(4);
        done = (burst_q.size() == bb + 3);
        chk("t1_bursts", done, 1);
        if (done) begin
            chk("t1_len0", burst_q[bb], 16);
            chk("t1_len1", burst_q[bb + 1], 16);
            chk("t1_len2", burst_q[bb + 2], 8);
        end
        chk("t1_strobes", strobe_cnt[0] - b0, 40);
        chk("t1_idle_gnt", GNT, 0);
        REQ = '0;
        step(2);

        // Round robin over 0, 1, 3 with FIFO kept non-empty
        do_reset();
        push(8);
        gb = grant_q.size(); bb = burst_q.size();
        REQ = 4'b1011;
        for (int c = 0; c < 400 && burst_q.size() < bb + 4; c++) begin
            step(1);
            if (wp - rp < 8) push(1);
        end
        done = (burst_q.size() >= bb + 4);
        chk("t2_done", done, 1);
        if (done) begin
            chk("t2_g0", grant_q[gb], 0);
            chk("t2_g1", grant_q[gb + 1], 1);
            chk("t2_g2", grant_q[gb + 2], 3);
            chk("t2_g3", grant_q[gb + 3], 0);
            for (int i = 0; i < 4; i++) chk("t2_len", burst_q[bb + i], 16);
        end
        REQ = '0;
        step(6);

        // Early release by requester 2 after 5 reads
        do_reset();
        push(30);
        b0 = rd_by[2]; b1 = strobe_cnt[2]; gb = grant_q.size();
        REQ = 4'b1100;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (rd_by[2] - b0 >= 5) break;
        end
        REQ = 4'b1000;
        for (int c = 0; c < 50 && grant_q.size() < gb + 2; c++) step(1);
        step(3);
        done = (grant_q.size() >= gb + 2);
        chk("t3_done", done, 1);
        if (done) begin
            chk("t3_first", grant_q[gb], 2);
            chk("t3_next", grant_q[gb + 1], 3);
        end
        chk("t3_strobes", strobe_cnt[2] - b1, 5);
        REQ = '0;
        step(4);

        // Empty boundary: 3 words, then one more written later
        do_reset();
        push(3);
        b0 = re_cnt; b1 = strobe_cnt[0];
        REQ = 4'b0001;
        step(20);
        chk("t4_reads", re_cnt - b0, 3);
        chk("t4_strobes", strobe_cnt[0] - b1, 3);
        chk("t4_idle", BUSY, 0);
        gb = grant_q.size();
        push(1);
        for (int c = 0; c < 10 && grant_q.size() == gb; c++) step(1);
        step(4);
        chk("t4_regrant", grant_q.size() - gb, 1);
        chk("t4_strobes2", strobe_cnt[0] - b1, 4);
        REQ = '0;
        step(3);

        // Async reset at read 7, then requester 0 first
        do_reset();
        push(20);
        b0 = re_cnt;
        REQ = 4'b0001;
        done = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLOCK);
            #2;
            if (re_cnt - b0 >= 7) begin done = 1; break; end
        end
        chk("t5_reached", done, 1);
        chk("t5_busy_before", BUSY, 1);
        RESET = 1'b0;
        #1;
        rst_checks("t5_async");
        REQ = 4'b1111;
        flush = 1'b1;
        @(posedge CLOCK);
        #1;
        flush = 1'b0;
        push(6);
        gb = grant_q.size();
        step(1);
        RESET = 1'b1;
        for (int c = 0; c < 10 && grant_q.size() == gb; c++) step(1);
        done = (grant_q.size() > gb);
        chk("t5_regrant", done, 1);
        if (done) chk("t5_first", grant_q[gb], 0);
        REQ = '0;
        step(4);

        // REQ drop and FIFO empty in the same cycle
        do_reset();
        push(4);
        b0 = re_cnt; b1 = strobe_cnt[0];
        REQ = 4'b0001;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (re_cnt - b0 >= 4) break;
        end
        REQ = '0;
        @(negedge CLOCK);
        chk("t6_re", FIFO_RE, 0);
        chk("t6_empty", FIFO_EMPTY, 1);
        chk("t6_last_strobe", DOUT_VALID, 4'b0001);
        @(negedge CLOCK);
        chk("t6_drain_gnt", GNT, 4'b0001);
        chk("t6_drain_dv", DOUT_VALID, 0);
        step(3);
        chk("t6_reads", re_cnt - b0, 4);
        chk("t6_strobes", strobe_cnt[0] - b1, 4);

        // Randomized soak against the reference model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            step(1);
            if ($urandom_range(0, 5) == 0) REQ = 4'($urandom);
            if ($urandom_range(0, 2) != 0 && wp - rp < 24) push(1);
        end
        REQ = '0;
        step(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
